// File: rtl/rom_stream_reader.sv
// Streams LENGTH consecutive ROM words from START_ADDR to a valid/ready consumer through a credit-limited skid FIFO.
// Optional build macro CHECKSUM_EN adds a running mod-2^DATA_WIDTH checksum output of accepted words.
module rom_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  rom_csb0,
    output logic [ADDR_WIDTH-1:0] rom_addr0,
    input  logic [DATA_WIDTH-1:0] rom_dout0,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
`ifdef CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic                  m_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 2;
    localparam int LW    = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_e;

    state_e state_q, state_d;

    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         issued_q, issued_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  csb_q, csb_d;
    logic                  req_last_q, req_last_d;
    logic                  cap_q, cap_d;
    logic                  cap_last_q, cap_last_d;
    logic                  done_q, done_d;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic [DATA_WIDTH-1:0] fifo_dat_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q;

    logic                  start_acc;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  last_pop;
    logic                  head_last;
    logic [CW-1:0]         credit_sum;

    assign head_last = fifo_last_q[rd_ptr_q];
    assign m_valid   = (count_q != '0);
    assign m_data    = m_valid ? fifo_dat_q[rd_ptr_q] : '0;
    assign m_last    = m_valid & head_last;
    assign rom_csb0  = csb_q;
    assign rom_addr0 = raddr_q;
    assign done      = done_q;

    // Credit covers the word on the ROM bus and the word the ROM is returning.
    assign credit_sum = CW'(count_q) + CW'(!csb_q) + CW'(cap_q);

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && (length != '0)) state_d = S_READ;
            S_READ:  if (issue && ((issued_q + LW'(1)) == len_q)) state_d = S_DRAIN;
            S_DRAIN: if (last_pop) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        start_acc = (state_q == S_IDLE) && start;
        issue     = (state_q == S_READ) && (issued_q != len_q) &&
                    (credit_sum < CW'(FIFO_DEPTH));
        push      = cap_q;
        pop       = m_valid && m_ready;
        last_pop  = pop && head_last;

        len_d      = start_acc ? length : len_q;
        addr_d     = addr_q;
        issued_d   = issued_q;
        if (start_acc) begin
            addr_d   = start_addr;
            issued_d = '0;
        end else if (issue) begin
            addr_d   = addr_q + ADDR_WIDTH'(1);
            issued_d = issued_q + LW'(1);
        end
        csb_d      = !issue;
        raddr_d    = issue ? addr_q : raddr_q;
        req_last_d = issue && (issued_q == (len_q - LW'(1)));
        cap_d      = !csb_q;
        cap_last_d = req_last_q;
        done_d     = (start_acc && (length == '0)) || (busy && last_pop);

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            len_q      <= '0;
            issued_q   <= '0;
            addr_q     <= '0;
            raddr_q    <= '0;
            csb_q      <= 1'b1;
            req_last_q <= 1'b0;
            cap_q      <= 1'b0;
            cap_last_q <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            len_q      <= len_d;
            issued_q   <= issued_d;
            addr_q     <= addr_d;
            raddr_q    <= raddr_d;
            csb_q      <= csb_d;
            req_last_q <= req_last_d;
            cap_q      <= cap_d;
            cap_last_q <= cap_last_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: m_data is masked while the FIFO is empty.
    always_ff @(posedge clk0) begin
        if (push) begin
            fifo_dat_q[wr_ptr_q]  <= rom_dout0;
            fifo_last_q[wr_ptr_q] <= cap_last_q;
        end
    end

`ifdef CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start_acc) begin
            sum_d = '0;
        end else if (pop) begin
            sum_d = sum_q + m_data;
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`endif

endmodule
